vec_operand_sequencer: RTL and testbench

// - Upstream neighbour of the EX-stage ALU. Accepts one vector instruction, walks its elements 0..vlen-1.
// - Per element: reads both source operands from the vector register file (1-cycle read latency).
// - Delivers {a, b, op, vd, el, last} to the ALU over a valid/ready port.
// - A 2-entry operand buffer absorbs RF latency and ALU stalls, so one element can issue per cycle.

---
 rtl/vec_pkg.sv | 40 ++++
 rtl/vec_operand_sequencer_if.sv | 50 +++++
 rtl/bsg_two_fifo.sv | 43 ++++
 rtl/vec_operand_sequencer.sv | 156 +++++++++++++++
 tb/tb_vec_operand_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_pkg.sv
// Shared types for the vector operand sequencer: element/register widths,
// sequencer state encoding, ALU opcode encoding and the operand packet that
// travels from the register-file read port to the EX-stage ALU.
package vec_pkg;

    localparam int unsigned vdw_p      = 32;
    localparam int unsigned els_p      = 8;
    localparam int unsigned num_regs_p = 8;
    localparam int unsigned op_width_p = 1;

    localparam int unsigned reg_w_p = $clog2(num_regs_p);
    localparam int unsigned el_w_p  = $clog2(els_p);
    localparam int unsigned len_w_p = $clog2(els_p + 1);

    typedef enum logic [1:0] {
        eIdle,
        eIssue,
        eDrain
    } eSeqState;

    typedef enum logic [op_width_p-1:0] {
        eAdd = op_width_p'(0),
        eSub = op_width_p'(1)
    } eAluOp;

    typedef struct packed {
        logic [vdw_p-1:0]   a;
        logic [vdw_p-1:0]   b;
        eAluOp              op;
        logic [reg_w_p-1:0] vd;
        logic [el_w_p-1:0]  el;
        logic               last;
    } vec_opnd_s;

    // Requested lengths beyond the register capacity walk the whole register.
    function automatic logic [len_w_p-1:0] clamp_vlen(input logic [len_w_p-1:0] vlen);
        return (vlen > len_w_p'(els_p)) ? len_w_p'(els_p) : vlen;
    endfunction

endpackage

// File: rtl/vec_operand_sequencer_if.sv
// Bus bundle of the operand sequencer: instruction port (v/ready + fields),
// register-file read port (strobe, addresses, element, 1-cycle data return),
// ALU operand port (valid/ready + packet) and the done pulse.
// slave = sequencer side, master = surrounding pipeline side.
interface vec_operand_sequencer_if;
    import vec_pkg::*;

    logic                  v_i;
    logic                  ready_o;
    logic [op_width_p-1:0] op_i;
    logic [reg_w_p-1:0]    vd_i;
    logic [reg_w_p-1:0]    vs1_i;
    logic [reg_w_p-1:0]    vs2_i;
    logic [len_w_p-1:0]    vlen_i;

    logic                  rf_r_v_o;
    logic [reg_w_p-1:0]    rf_r_addr0_o;
    logic [reg_w_p-1:0]    rf_r_addr1_o;
    logic [el_w_p-1:0]     rf_r_el_o;
    logic [vdw_p-1:0]      rf_r_data0_i;
    logic [vdw_p-1:0]      rf_r_data1_i;

    logic                  alu_v_o;
    logic                  alu_ready_i;
    logic [vdw_p-1:0]      alu_a_o;
    logic [vdw_p-1:0]      alu_b_o;
    logic [op_width_p-1:0] alu_op_o;
    logic [reg_w_p-1:0]    alu_vd_o;
    logic [el_w_p-1:0]     alu_el_o;
    logic                  alu_last_o;

    logic                  done_o;

    modport slave (
        input  v_i, op_i, vd_i, vs1_i, vs2_i, vlen_i,
        input  rf_r_data0_i, rf_r_data1_i, alu_ready_i,
        output ready_o, rf_r_v_o, rf_r_addr0_o, rf_r_addr1_o, rf_r_el_o,
        output alu_v_o, alu_a_o, alu_b_o, alu_op_o, alu_vd_o, alu_el_o, alu_last_o,
        output done_o
    );

    modport master (
        output v_i, op_i, vd_i, vs1_i, vs2_i, vlen_i,
        output rf_r_data0_i, rf_r_data1_i, alu_ready_i,
        input  ready_o, rf_r_v_o, rf_r_addr0_o, rf_r_addr1_o, rf_r_el_o,
        input  alu_v_o, alu_a_o, alu_b_o, alu_op_o, alu_vd_o, alu_el_o, alu_last_o,
        input  done_o
    );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/yumi dequeue.
// Ports: clk_i, reset_i (async, active high); v_i/data_i enqueue;
// v_o/data_o head; yumi_i pops the head. The writer guarantees a free slot
// whenever v_i is high, so no ready output is provided.
module bsg_two_fifo #(
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [2];
    logic               wptr_q;
    logic               rptr_q;
    logic [1:0]         cnt_q;

    // Pointers and occupancy.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (v_i)    wptr_q <= ~wptr_q;
            if (yumi_i) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + 2'(v_i) - 2'(yumi_i);
        end
    end

    // Storage needs no reset; occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (v_i) mem_q[wptr_q] <= data_i;
    end

    assign v_o    = (cnt_q != 2'd0);
    assign data_o = mem_q[rptr_q];

endmodule

// File: rtl/vec_operand_sequencer.sv
// Vector operand sequencer: accepts one instruction, reads both source
// operands for elements 0..vlen-1 from the register file and streams
// {a, b, op, vd, el, last} to the ALU through a two-entry buffer.
// Ports: clk_i, reset_i (async, active high) and the bus interface
// (instruction in, RF read port, ALU operand port, done pulse).
module vec_operand_sequencer
    import vec_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_i,
    vec_operand_sequencer_if.slave bus
);

    eSeqState           state_q, state_d;
    logic [el_w_p-1:0]  el_q, el_d;
    logic [len_w_p-1:0] vlen_q, vlen_d;
    eAluOp              op_q, op_d;
    logic [reg_w_p-1:0] vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic [1:0]         credit_q, credit_d;
    logic               pend_q, pend_d;
    logic [el_w_p-1:0]  pend_el_q, pend_el_d;
    logic               pend_last_q, pend_last_d;
    logic               ready_q, ready_d;
    logic               zero_done_q, zero_done_d;

    logic               rd_c, deq_c, fifo_v_c, el_last_c;
    logic [len_w_p-1:0] vlen_clamped_c;
    vec_opnd_s          enq_c, head_c;

    assign vlen_clamped_c = clamp_vlen(bus.vlen_i);
    assign deq_c          = fifo_v_c & bus.alu_ready_i;
    assign el_last_c      = (len_w_p'(el_q) == (vlen_q - len_w_p'(1)));

    // Read returned last cycle, tagged with the element it was issued for.
    always_comb begin
        enq_c.a    = bus.rf_r_data0_i;
        enq_c.b    = bus.rf_r_data1_i;
        enq_c.op   = op_q;
        enq_c.vd   = vd_q;
        enq_c.el   = pend_el_q;
        enq_c.last = pend_last_q;
    end

    // Next-state: instruction latch, element walk and credit accounting.
    always_comb begin
        state_d     = state_q;
        el_d        = el_q;
        vlen_d      = vlen_q;
        op_d        = op_q;
        vd_d        = vd_q;
        vs1_d       = vs1_q;
        vs2_d       = vs2_q;
        pend_d      = 1'b0;
        pend_el_d   = pend_el_q;
        pend_last_d = pend_last_q;
        zero_done_d = 1'b0;
        rd_c        = 1'b0;

        case (state_q)
            eIdle: begin
                if (bus.v_i && ready_q) begin
                    op_d   = eAluOp'(bus.op_i);
                    vd_d   = bus.vd_i;
                    vs1_d  = bus.vs1_i;
                    vs2_d  = bus.vs2_i;
                    vlen_d = vlen_clamped_c;
                    el_d   = '0;
                    if (vlen_clamped_c == '0) zero_done_d = 1'b1;
                    else                      state_d     = eIssue;
                end
            end
            eIssue: begin
                // A slot freed by this cycle's dequeue is reusable at once,
                // which is what sustains one element per cycle.
                if ((credit_q < 2'd2) || deq_c) begin
                    rd_c        = 1'b1;
                    el_d        = el_q + el_w_p'(1);
                    pend_d      = 1'b1;
                    pend_el_d   = el_q;
                    pend_last_d = el_last_c;
                    if (el_last_c) state_d = eDrain;
                end
            end
            eDrain: begin
                if (deq_c && head_c.last) state_d = eIdle;
            end
            default: state_d = eIdle;
        endcase

        // Credits cover buffered entries plus reads still in flight.
        credit_d = credit_q + 2'(rd_c) - 2'(deq_c);
        ready_d  = (state_d == eIdle);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= eIdle;
            el_q        <= '0;
            vlen_q      <= '0;
            op_q        <= eAdd;
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            credit_q    <= 2'd0;
            pend_q      <= 1'b0;
            pend_el_q   <= '0;
            pend_last_q <= 1'b0;
            ready_q     <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            el_q        <= el_d;
            vlen_q      <= vlen_d;
            op_q        <= op_d;
            vd_q        <= vd_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            credit_q    <= credit_d;
            pend_q      <= pend_d;
            pend_el_q   <= pend_el_d;
            pend_last_q <= pend_last_d;
            ready_q     <= ready_d;
            zero_done_q <= zero_done_d;
        end
    end

    bsg_two_fifo #(
        .width_p ($bits(vec_opnd_s))
    ) u_opnd_buf (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (pend_q),
        .data_i  (enq_c),
        .v_o     (fifo_v_c),
        .data_o  (head_c),
        .yumi_i  (deq_c)
    );

    assign bus.ready_o      = ready_q;
    assign bus.rf_r_v_o     = rd_c;
    assign bus.rf_r_addr0_o = vs1_q;
    assign bus.rf_r_addr1_o = vs2_q;
    assign bus.rf_r_el_o    = el_q;

    assign bus.alu_v_o      = fifo_v_c;
    assign bus.alu_a_o      = head_c.a;
    assign bus.alu_b_o      = head_c.b;
    assign bus.alu_op_o     = head_c.op;
    assign bus.alu_vd_o     = head_c.vd;
    assign bus.alu_el_o     = head_c.el;
    assign bus.alu_last_o   = head_c.last;

    // Zero-length instructions finish from the idle state a cycle after accept.
    assign bus.done_o = zero_done_q | ((state_q == eDrain) & deq_c & head_c.last);

endmodule

// File: tb/tb_vec_operand_sequencer.sv
// Directed bench for vec_operand_sequencer with a 1-cycle RF model and an
// ALU-side monitor collecting handshaken packets.
module tb_vec_operand_sequencer;
    import vec_pkg::*;

    logic clk = 1'b0;
    logic rst;

    vec_operand_sequencer_if bus();

    vec_operand_sequencer dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [vdw_p-1:0] rf [num_regs_p][els_p];
    vec_opnd_s pkts[$];
    int        deq_cyc[$];
    int        cyc = 0;
    int        done_cnt = 0;
    int        done_cyc = -1;
    int        first_v_cyc = -1;
    int        rd_total = 0;
    int        outst = 0;
    int        max_out = 0;
    int        hold_err = 0;
    bit        rdy_bp = 1'b0;
    int        pat = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file: data returned exactly one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.rf_r_v_o) begin
            bus.rf_r_data0_i <= rf[bus.rf_r_addr0_o][bus.rf_r_el_o];
            bus.rf_r_data1_i <= rf[bus.rf_r_addr1_o][bus.rf_r_el_o];
        end
    end

    // ALU ready: constant 1, or the repeating 1,0,0 backpressure pattern.
    initial begin
        bus.alu_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.alu_ready_i = rdy_bp ? (pat % 3 == 0) : 1'b1;
            pat++;
        end
    end

    // Monitor sampling at the falling edge.
    initial begin
        vec_opnd_s cur;
        vec_opnd_s held;
        bit        stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur.a    = bus.alu_a_o;
            cur.b    = bus.alu_b_o;
            cur.op   = eAluOp'(bus.alu_op_o);
            cur.vd   = bus.alu_vd_o;
            cur.el   = bus.alu_el_o;
            cur.last = bus.alu_last_o;
            if (rst) begin
                outst = 0;
                stall = 1'b0;
            end else begin
                if (stall && (!bus.alu_v_o || cur != held)) hold_err++;
                if (bus.alu_v_o && first_v_cyc < 0) first_v_cyc = cyc;
                if (bus.alu_v_o && bus.alu_ready_i) begin
                    pkts.push_back(cur);
                    deq_cyc.push_back(cyc);
                end
                if (bus.done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (bus.rf_r_v_o) rd_total++;
                outst = outst + int'(bus.rf_r_v_o) - int'(bus.alu_v_o && bus.alu_ready_i);
                if (outst > max_out) max_out = outst;
                stall = bus.alu_v_o && !bus.alu_ready_i;
                held  = cur;
            end
        end
    end

    task automatic clear();
        pkts.delete();
        deq_cyc.delete();
        first_v_cyc = -1;
        max_out     = 0;
        hold_err    = 0;
        rd_total    = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents an instruction and returns once it is accepted; v_i stays high.
    task automatic send(input int op, input int vd, input int vs1, input int vs2,
                        input int vlen, output int acc);
        int n;
        n = 0;
        bus.op_i   = op_width_p'(op);
        bus.vd_i   = reg_w_p'(vd);
        bus.vs1_i  = reg_w_p'(vs1);
        bus.vs2_i  = reg_w_p'(vs2);
        bus.vlen_i = len_w_p'(vlen);
        bus.v_i    = 1'b1;
        while (!bus.ready_o && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_in_time", 64'(n < 60), 64'd1);
        @(posedge clk);
        acc = cyc;
        #1;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(done_cnt), 64'(target));
    endtask

    task automatic check_stream(input string t, input int n, input int vs1, input int vs2,
                                input int vd, input int op);
        chk({t, "_npkt"}, 64'(pkts.size()), 64'(n));
        for (int i = 0; i < n && i < pkts.size(); i++) begin
            chk($sformatf("%s_el%0d", t, i),   64'(pkts[i].el),   64'(i));
            chk($sformatf("%s_a%0d", t, i),    64'(pkts[i].a),    64'(rf[vs1][i]));
            chk($sformatf("%s_b%0d", t, i),    64'(pkts[i].b),    64'(rf[vs2][i]));
            chk($sformatf("%s_vd%0d", t, i),   64'(pkts[i].vd),   64'(vd));
            chk($sformatf("%s_op%0d", t, i),   64'(pkts[i].op),   64'(op));
            chk($sformatf("%s_last%0d", t, i), 64'(pkts[i].last), 64'(i == n - 1));
        end
    endtask

    initial begin
        int acc;
        int acc2;
        int base;
        int d1;
        int n;

        rst        = 1'b1;
        bus.v_i    = 1'b0;
        bus.op_i   = '0;
        bus.vd_i   = '0;
        bus.vs1_i  = '0;
        bus.vs2_i  = '0;
        bus.vlen_i = '0;
        for (int r = 0; r < int'(num_regs_p); r++)
            for (int e = 0; e < int'(els_p); e++)
                rf[r][e] = vdw_p'(32'h1000 * r + e);
        for (int e = 0; e < 4; e++) begin
            rf[1][e] = vdw_p'(e + 1);
            rf[2][e] = vdw_p'(10 * (e + 1));
        end

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_alu_v", 64'(bus.alu_v_o), 64'd0);
        chk("rst_rf_v",  64'(bus.rf_r_v_o), 64'd0);
        chk("rst_done",  64'(bus.done_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        chk("idle_ready", 64'(bus.ready_o), 64'd1);

        // Basic: vlen=4, a={1,2,3,4}, b={10,20,30,40}, sub.
        clear();
        send(1, 3, 1, 2, 4, acc);
        bus.v_i = 1'b0;
        wait_done(1);
        idle(3);
        check_stream("basic", 4, 1, 2, 3, 1);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        // Accept edge, then RF read cycle, then data lands: visible 3rd sample.
        chk("basic_first_lat", 64'(first_v_cyc - acc), 64'd3);
        if (deq_cyc.size() == 4) begin
            chk("basic_burst", 64'(deq_cyc[3] - deq_cyc[0]), 64'd3);
            chk("basic_done_cyc", 64'(done_cyc), 64'(deq_cyc[3]));
        end
        chk("basic_ready_back", 64'(bus.ready_o), 64'd1);

        // Backpressure: alu_ready 1,0,0 repeating, vlen=8.
        rdy_bp = 1'b1;
        clear();
        base = done_cnt;
        send(0, 4, 3, 4, 8, acc);
        bus.v_i = 1'b0;
        wait_done(base + 1);
        idle(3);
        rdy_bp = 1'b0;
        idle(1);
        check_stream("bp", 8, 3, 4, 4, 0);
        chk("bp_hold_stable", 64'(hold_err), 64'd0);
        chk("bp_max_outst", 64'(max_out), 64'd2);
        chk("bp_reads", 64'(rd_total), 64'd8);
        chk("bp_done_cnt", 64'(done_cnt), 64'(base + 1));

        // vlen=0: done one cycle after accept, no reads, no packets.
        clear();
        base = done_cnt;
        send(0, 1, 1, 2, 0, acc);
        bus.v_i = 1'b0;
        idle(4);
        chk("z_done_cnt", 64'(done_cnt), 64'(base + 1));
        chk("z_done_lat", 64'(done_cyc - acc), 64'd1);
        chk("z_npkt", 64'(pkts.size()), 64'd0);
        chk("z_reads", 64'(rd_total), 64'd0);

        // vlen=15 clamps to 8 elements.
        clear();
        base = done_cnt;
        send(1, 6, 5, 7, 15, acc);
        bus.v_i = 1'b0;
        wait_done(base + 1);
        idle(3);
        check_stream("clamp", 8, 5, 7, 6, 1);
        chk("clamp_reads", 64'(rd_total), 64'd8);

        // vlen=1: a single packet carrying last.
        clear();
        base = done_cnt;
        send(0, 2, 1, 2, 1, acc);
        bus.v_i = 1'b0;
        wait_done(base + 1);
        idle(3);
        check_stream("one", 1, 1, 2, 2, 0);

        // Reset after 3 of 8 packets.
        clear();
        base = done_cnt;
        send(0, 7, 3, 4, 8, acc);
        bus.v_i = 1'b0;
        n = 0;
        while (pkts.size() < 3 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        #1;
        chk("mr_alu_v", 64'(bus.alu_v_o), 64'd0);
        chk("mr_ready", 64'(bus.ready_o), 64'd0);
        chk("mr_rf_v",  64'(bus.rf_r_v_o), 64'd0);
        chk("mr_done",  64'(bus.done_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        chk("mr_ready_after", 64'(bus.ready_o), 64'd1);
        chk("mr_no_done", 64'(done_cnt), 64'(base));
        chk("mr_npkt", 64'(pkts.size()), 64'd3);
        clear();
        send(1, 1, 1, 2, 2, acc);
        bus.v_i = 1'b0;
        wait_done(base + 1);
        idle(3);
        check_stream("mr_new", 2, 1, 2, 1, 1);

        // Back-to-back with v_i held: vd=2 (3 elements) then vd=5 (2 elements).
        clear();
        base = done_cnt;
        send(0, 2, 1, 2, 3, acc);
        send(1, 5, 3, 4, 2, acc2);
        d1 = done_cyc;
        bus.v_i = 1'b0;
        wait_done(base + 2);
        idle(3);
        chk("b2b_gap", 64'(acc2 - d1), 64'd1);
        chk("b2b_npkt", 64'(pkts.size()), 64'd5);
        for (int i = 0; i < pkts.size(); i++) begin
            chk($sformatf("b2b_vd%0d", i), 64'(pkts[i].vd), (i < 3) ? 64'd2 : 64'd5);
            chk($sformatf("b2b_el%0d", i), 64'(pkts[i].el), (i < 3) ? 64'(i) : 64'(i - 3));
            chk($sformatf("b2b_a%0d", i),  64'(pkts[i].a),
                (i < 3) ? 64'(rf[1][i]) : 64'(rf[3][i - 3]));
        end
        chk("b2b_done_cnt", 64'(done_cnt), 64'(base + 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected $finish before timeout");
        $fatal(1);
    end

endmodule
